// File: rtl/cell_window_builder_if.sv
// Pixel-pair stream in, 3x3 cell stream out, between source, window builder and cell processor.
// No storage: pure signal bundle; the builder is registered with one cycle of latency.
// Backpressure: in_valid/in_ready upstream, cell_valid/cell_ready downstream; cell_count only with CELL_COUNT_EN.
interface cell_window_builder_if #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int OPCODE_WIDTH = 4,
  parameter int USER_WIDTH   = 8
);
  localparam int CELL_DEPTH = 9 * PIXEL_WIDTH;

  logic                    sof;
  logic                    in_valid;
  logic                    in_ready;
  logic [PIXEL_WIDTH-1:0]  pix_a;
  logic [PIXEL_WIDTH-1:0]  pix_b;
  logic [OPCODE_WIDTH-1:0] cfg_opcode;
  logic [USER_WIDTH-1:0]   cfg_user;
  logic [CELL_DEPTH-1:0]   cellA;
  logic [CELL_DEPTH-1:0]   cellB;
  logic [USER_WIDTH-1:0]   userInputA;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    cell_valid;
  logic                    cell_ready;
  logic                    cell_last;
`ifdef CELL_COUNT_EN
  logic [15:0]             cell_count;
`endif

  // Pixel source / cell consumer side
  modport master (
    output sof, in_valid, pix_a, pix_b, cfg_opcode, cfg_user, cell_ready,
    input  in_ready, cellA, cellB, userInputA, opcode, cell_valid, cell_last
`ifdef CELL_COUNT_EN
    , input cell_count
`endif
  );

  // Window builder side
  modport slave (
    input  sof, in_valid, pix_a, pix_b, cfg_opcode, cfg_user, cell_ready,
    output in_ready, cellA, cellB, userInputA, opcode, cell_valid, cell_last
`ifdef CELL_COUNT_EN
    , output cell_count
`endif
  );
endinterface

// File: rtl/cell_window_builder.sv
// Builds 3x3 windows for two pixel channels from a raster stream using two line buffers per channel.
// Latency: window valid one cycle after the accept of its bottom-right pixel; 1 cell/cycle sustained.
// Backpressure: in_ready = !cell_valid || cell_ready, no skid; optional cell counter under CELL_COUNT_EN.
module cell_window_builder #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int IMG_WIDTH    = 64,
  parameter int IMG_HEIGHT   = 64,
  parameter int OPCODE_WIDTH = 4,
  parameter int USER_WIDTH   = 8,
  parameter int CELL_DEPTH   = 9 * PIXEL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  cell_window_builder_if.slave bus
);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int PW    = PIXEL_WIDTH;

  logic [COL_W-1:0]        col, effCol;
  logic [ROW_W-1:0]        row, effRow;
  logic                    inReady, accept, handshake, atOrigin, completes, lastPos;
  logic [PW-1:0]           lineA0 [IMG_WIDTH];  // row-1
  logic [PW-1:0]           lineA1 [IMG_WIDTH];  // row-2
  logic [PW-1:0]           lineB0 [IMG_WIDTH];
  logic [PW-1:0]           lineB1 [IMG_WIDTH];
  logic [CELL_DEPTH-1:0]   winA, winB, winANext, winBNext;
  logic                    cellValidQ, cellLastQ;
  logic [OPCODE_WIDTH-1:0] opcodeQ;
  logic [USER_WIDTH-1:0]   userQ;

  assign inReady   = !cellValidQ || bus.cell_ready;
  assign accept    = bus.in_valid && inReady;
  assign handshake = cellValidQ && bus.cell_ready;
  // sof relocates the incoming pixel to the frame origin
  assign effCol    = bus.sof ? '0 : col;
  assign effRow    = bus.sof ? '0 : row;
  assign atOrigin  = (effCol == '0) && (effRow == '0);
  assign completes = accept && (effRow >= ROW_W'(2)) && (effCol >= COL_W'(2));
  assign lastPos   = (effRow == ROW_W'(IMG_HEIGHT - 1)) && (effCol == COL_W'(IMG_WIDTH - 1));

  // Next window: shift every row left one pixel, new column enters at c=2 (top=row-2, bottom=current)
  always_comb begin
    winANext = winA;
    winBNext = winB;
    for (int r = 0; r < 3; r++) begin
      winANext[(r*3)*PW +: PW]   = winA[(r*3+1)*PW +: PW];
      winANext[(r*3+1)*PW +: PW] = winA[(r*3+2)*PW +: PW];
      winBNext[(r*3)*PW +: PW]   = winB[(r*3+1)*PW +: PW];
      winBNext[(r*3+1)*PW +: PW] = winB[(r*3+2)*PW +: PW];
    end
    winANext[2*PW +: PW] = lineA1[effCol];
    winANext[5*PW +: PW] = lineA0[effCol];
    winANext[8*PW +: PW] = bus.pix_a;
    winBNext[2*PW +: PW] = lineB1[effCol];
    winBNext[5*PW +: PW] = lineB0[effCol];
    winBNext[8*PW +: PW] = bus.pix_b;
  end

  // Raster position of the next pixel; wraps at end of row and end of frame
  always_ff @(posedge clk) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (effCol == COL_W'(IMG_WIDTH - 1)) begin
        col <= '0;
        row <= (effRow == ROW_W'(IMG_HEIGHT - 1)) ? '0 : effRow + ROW_W'(1);
      end else begin
        col <= effCol + COL_W'(1);
        row <= effRow;
      end
    end
  end

  // Line buffers age by one row per column write; contents are refilled before they are ever used
  always_ff @(posedge clk) begin
    if (accept) begin
      lineA1[effCol] <= lineA0[effCol];
      lineA0[effCol] <= bus.pix_a;
      lineB1[effCol] <= lineB0[effCol];
      lineB0[effCol] <= bus.pix_b;
    end
  end

  // Window registers double as the cell outputs; no accept happens while a cell is held
  always_ff @(posedge clk) begin
    if (!rst) begin
      winA <= '0;
      winB <= '0;
    end else if (accept) begin
      winA <= winANext;
      winB <= winBNext;
    end
  end

  // Cell valid/last: set by a completing pixel, cleared by a handshake with nothing new behind it
  always_ff @(posedge clk) begin
    if (!rst) begin
      cellValidQ <= 1'b0;
      cellLastQ  <= 1'b0;
    end else if (completes) begin
      cellValidQ <= 1'b1;
      cellLastQ  <= lastPos;
    end else if (bus.cell_ready) begin
      cellValidQ <= 1'b0;
      cellLastQ  <= 1'b0;
    end
  end

  // Per-frame opcode and user value, captured at the origin pixel
  always_ff @(posedge clk) begin
    if (!rst) begin
      opcodeQ <= '0;
      userQ   <= '0;
    end else if (accept && atOrigin) begin
      opcodeQ <= bus.cfg_opcode;
      userQ   <= bus.cfg_user;
    end
  end

`ifdef CELL_COUNT_EN
  logic [15:0] cellCount;

  // Cells delivered this frame; origin clear wins over a same-cycle handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      cellCount <= '0;
    end else if (accept && atOrigin) begin
      cellCount <= '0;
    end else if (handshake && (cellCount != 16'hFFFF)) begin
      cellCount <= cellCount + 16'd1;
    end
  end

  assign bus.cell_count = cellCount;
`endif

  assign bus.in_ready   = inReady;
  assign bus.cellA      = winA;
  assign bus.cellB      = winB;
  assign bus.opcode     = opcodeQ;
  assign bus.userInputA = userQ;
  assign bus.cell_valid = cellValidQ;
  assign bus.cell_last  = cellLastQ;
endmodule

// File: tb/tb_cell_window_builder.sv
// Randomized and directed stimulus for cell_window_builder on a 4x4 image against a frame-array model.
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
// Ready stalls, resets and mid-frame sof exercise the backpressure and discard paths.
module tb_cell_window_builder;
  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int OW = 4;
  localparam int UW = 8;
  localparam int CD = 9 * PW;

  typedef struct {
    logic [CD-1:0] a;
    logic [CD-1:0] b;
    logic [OW-1:0] op;
    logic [UW-1:0] user;
    logic          last;
  } cell_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cell_window_builder_if #(.PIXEL_WIDTH(PW), .OPCODE_WIDTH(OW), .USER_WIDTH(UW)) bus ();

  cell_window_builder #(
    .PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .OPCODE_WIDTH(OW), .USER_WIDTH(UW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  cell_t         expQ[$];
  int            fa [H][W];
  int            fb [H][W];
  int            mRow, mCol, mCount, nCells;
  logic [OW-1:0] mOp;
  logic [UW-1:0] mUser;
  bit            rstCheck, firstArm, stallArm, holdLow, randReady, randGaps, randSof;
  int            stallLeft;
  logic [CD-1:0] firstA, firstB;
  int            compared, mismatched;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [CD-1:0] windowOf(input bit chanB, input int r, input int c);
    logic [CD-1:0] w;
    int v;
    w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        v = chanB ? fb[r-2+dr][c-2+dc] : fa[r-2+dr][c-2+dc];
        w[(dr*3+dc)*PW +: PW] = PW'(v);
      end
    return w;
  endfunction

  // Compare DUT against the model for this cycle, then advance the model across the coming edge
  task automatic observe(output bit acc);
    bit    mValid, hs, origin;
    cell_t c;
    acc    = 1'b0;
    mValid = (expQ.size() != 0);
    if (rstCheck) begin
      check("rst_cellA", 128'(bus.cellA), 128'(0));
      check("rst_cellB", 128'(bus.cellB), 128'(0));
      check("rst_opcode", 128'(bus.opcode), 128'(0));
      check("rst_user", 128'(bus.userInputA), 128'(0));
      check("rst_last", 128'(bus.cell_last), 128'(0));
      rstCheck = 1'b0;
    end
    check("cell_valid", 128'(bus.cell_valid), 128'(mValid));
    check("in_ready", 128'(bus.in_ready), 128'(!mValid || bus.cell_ready));
    if (mValid) begin
      c = expQ[0];
      check("cellA", 128'(bus.cellA), 128'(c.a));
      check("cellB", 128'(bus.cellB), 128'(c.b));
      check("opcode", 128'(bus.opcode), 128'(c.op));
      check("userInputA", 128'(bus.userInputA), 128'(c.user));
      check("cell_last", 128'(bus.cell_last), 128'(c.last));
      if (firstArm) begin
        check("first_cellA", 128'(bus.cellA), 128'(firstA));
        check("first_cellB", 128'(bus.cellB), 128'(firstB));
        firstArm = 1'b0;
      end
    end
`ifdef CELL_COUNT_EN
    check("cell_count", 128'(bus.cell_count), 128'(mCount));
`endif
    if (!rst) begin
      expQ.delete();
      mRow = 0; mCol = 0; mCount = 0; mOp = '0; mUser = '0;
      rstCheck = 1'b1;
      return;
    end
    hs = mValid && bus.cell_ready;
    if (hs) begin
      void'(expQ.pop_front());
      nCells++;
    end
    acc    = bus.in_valid && (!mValid || bus.cell_ready);
    origin = 1'b0;
    if (acc) begin
      if (bus.sof) begin mRow = 0; mCol = 0; end
      origin = (mRow == 0) && (mCol == 0);
      if (origin) begin mOp = bus.cfg_opcode; mUser = bus.cfg_user; end
      fa[mRow][mCol] = int'(bus.pix_a);
      fb[mRow][mCol] = int'(bus.pix_b);
      if (mRow >= 2 && mCol >= 2) begin
        c.a = windowOf(1'b0, mRow, mCol);
        c.b = windowOf(1'b1, mRow, mCol);
        c.op = mOp;
        c.user = mUser;
        c.last = (mRow == H-1) && (mCol == W-1);
        expQ.push_back(c);
      end
      mCol++;
      if (mCol == W) begin
        mCol = 0;
        mRow = (mRow == H-1) ? 0 : mRow + 1;
      end
    end
    if (acc && origin) mCount = 0;
    else if (hs && mCount < 65535) mCount++;
  endtask

  task automatic cycle(output bit acc);
    if (stallArm && bus.cell_valid) begin stallLeft = 5; stallArm = 1'b0; end
    if (holdLow) bus.cell_ready = 1'b0;
    else if (stallLeft > 0) begin bus.cell_ready = 1'b0; stallLeft--; end
    else bus.cell_ready = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    observe(acc);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    bus.in_valid = 1'b0;
    bus.sof = 1'b0;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic sendPixel(input logic [PW-1:0] a, input logic [PW-1:0] b, input bit s);
    bit acc;
    if (randGaps) idle($urandom_range(0, 2));
    bus.in_valid = 1'b1;
    bus.pix_a = a;
    bus.pix_b = b;
    bus.sof = s;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) cycle(acc);
    if (!acc) check("accept_timeout", 128'(0), 128'(1));
    bus.in_valid = 1'b0;
    bus.sof = 1'b0;
  endtask

  task automatic sendFrame(input bit withSof, input bit randPix, input int startIdx, input int stopIdx,
                           input int chgAt, input logic [OW-1:0] chgOp, input logic [UW-1:0] chgUser);
    logic [PW-1:0] a;
    bit s;
    for (int i = startIdx; i < stopIdx; i++) begin
      if (i == chgAt) begin bus.cfg_opcode = chgOp; bus.cfg_user = chgUser; end
      a = randPix ? PW'($urandom) : PW'(i);
      s = (withSof && i == startIdx) || (randSof && $urandom_range(0, 39) == 0);
      sendPixel(a, randPix ? PW'($urandom) : a + PW'(100), s);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int firstVals [9];
    compared = 0; mismatched = 0; nCells = 0;
    firstVals = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    for (int k = 0; k < 9; k++) begin
      firstA[k*PW +: PW] = PW'(firstVals[k]);
      firstB[k*PW +: PW] = PW'(firstVals[k] + 100);
    end
    bus.sof = 0; bus.in_valid = 0; bus.pix_a = 0; bus.pix_b = 0;
    bus.cfg_opcode = 0; bus.cfg_user = 0; bus.cell_ready = 1;
    @(negedge clk);
    idle(2);
    rst = 1'b1;
    idle(1);

    // Directed 4x4 frame, ready always high
    bus.cfg_opcode = 4'd3; bus.cfg_user = 8'h55;
    firstArm = 1'b1;
    n0 = nCells;
    sendFrame(1'b1, 1'b0, 0, W*H, -1, '0, '0);
    idle(3);
    check("t1_cell_total", 128'(nCells - n0), 128'(4));
`ifdef CELL_COUNT_EN
    #1 check("t1_count", 128'(bus.cell_count), 128'(4));
`endif

    // Same frame with a 5-cycle stall on the first cell
    stallArm = 1'b1;
    n0 = nCells;
    sendPixel(8'd0, 8'd100, 1'b1);
`ifdef CELL_COUNT_EN
    #1 check("t2_count_clear", 128'(bus.cell_count), 128'(0));
`endif
    sendFrame(1'b0, 1'b0, 1, W*H, -1, '0, '0);
    idle(3);
    check("t2_cell_total", 128'(nCells - n0), 128'(4));

    // Config change mid-frame, then a wrapped frame without sof
    bus.cfg_opcode = 4'd3; bus.cfg_user = 8'h55;
    sendFrame(1'b1, 1'b0, 0, W*H, 5, 4'd7, 8'hAA);
    sendFrame(1'b0, 1'b0, 0, W*H, -1, '0, '0);
    idle(3);

    // sof arrives at (2,1): partial frame discarded
    sendFrame(1'b1, 1'b0, 0, 2*W+1, -1, '0, '0);
    n0 = nCells;
    sendFrame(1'b1, 1'b1, 0, W*H, -1, '0, '0);
    idle(3);
    check("t4_cell_total", 128'(nCells - n0), 128'(4));

    // Reset while a cell is pending, then a frame without sof
    holdLow = 1'b1;
    sendFrame(1'b1, 1'b0, 0, 2*W+3, -1, '0, '0);
    idle(1);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    holdLow = 1'b0;
    n0 = nCells;
    sendFrame(1'b0, 1'b1, 0, W*H, -1, '0, '0);
    idle(3);
    check("t5_cell_total", 128'(nCells - n0), 128'(4));

    // Random traffic: gaps, ready jitter, occasional sof, per-frame config
    randReady = 1'b1; randGaps = 1'b1; randSof = 1'b1;
    for (int f = 0; f < 8; f++) begin
      bus.cfg_opcode = OW'($urandom);
      bus.cfg_user = UW'($urandom);
      sendFrame(1'b0, 1'b1, 0, W*H, $urandom_range(0, W*H-1), OW'($urandom), UW'($urandom));
    end
    randReady = 1'b0; randGaps = 1'b0; randSof = 1'b0;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
